// File: rtl/ysyx_22050550_axi_rd_arbiter.sv
// rtl/ysyx_22050550_axi_rd_arbiter.sv - two-master round-robin AXI read arbiter with DCache write bypass
module ysyx_22050550_axi_rd_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    // ICache read port
    input  logic              m0_ar_valid,
    input  logic [ADDR_W-1:0] m0_ar_addr,
    input  logic [7:0]        m0_ar_len,
    input  logic [2:0]        m0_ar_size,
    input  logic [1:0]        m0_ar_burst,
    output logic              m0_ar_ready,
    output logic              m0_r_valid,
    output logic [DATA_W-1:0] m0_r_data,
    output logic              m0_r_last,
    input  logic              m0_r_ready,
    // DCache read port
    input  logic              m1_ar_valid,
    input  logic [ADDR_W-1:0] m1_ar_addr,
    input  logic [7:0]        m1_ar_len,
    input  logic [2:0]        m1_ar_size,
    input  logic [1:0]        m1_ar_burst,
    output logic              m1_ar_ready,
    output logic              m1_r_valid,
    output logic [DATA_W-1:0] m1_r_data,
    output logic              m1_r_last,
    input  logic              m1_r_ready,
    // DCache write port
    input  logic              m1_aw_valid,
    input  logic [ADDR_W-1:0] m1_aw_addr,
    input  logic [7:0]        m1_aw_len,
    input  logic [2:0]        m1_aw_size,
    input  logic [1:0]        m1_aw_burst,
    output logic              m1_aw_ready,
    input  logic              m1_w_valid,
    input  logic [DATA_W-1:0] m1_w_data,
    input  logic [7:0]        m1_w_strb,
    output logic              m1_w_ready,
    // SRAM slave
    output logic              s_ar_valid,
    output logic [ADDR_W-1:0] s_ar_addr,
    output logic [7:0]        s_ar_len,
    output logic [2:0]        s_ar_size,
    output logic [1:0]        s_ar_burst,
    input  logic              s_ar_ready,
    input  logic              s_r_valid,
    input  logic [DATA_W-1:0] s_r_data,
    input  logic              s_r_last,
    output logic              s_r_ready,
    output logic              s_aw_valid,
    output logic [ADDR_W-1:0] s_aw_addr,
    output logic [7:0]        s_aw_len,
    output logic [2:0]        s_aw_size,
    output logic [1:0]        s_aw_burst,
    input  logic              s_aw_ready,
    output logic              s_w_valid,
    output logic [DATA_W-1:0] s_w_data,
    output logic [7:0]        s_w_strb,
    input  logic              s_w_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   w_owner_nxt;
    logic   r_last_owner;
    logic   w_last_owner_nxt;
    logic   w_owner_ar_valid;
    logic   w_owner_r_ready;

    // Owner is frozen from ADDR until the last R beat, so these muxes stay stable while s_ar_valid is high.
    assign s_ar_addr        = r_owner ? m1_ar_addr  : m0_ar_addr;
    assign s_ar_len         = r_owner ? m1_ar_len   : m0_ar_len;
    assign s_ar_size        = r_owner ? m1_ar_size  : m0_ar_size;
    assign s_ar_burst       = r_owner ? m1_ar_burst : m0_ar_burst;
    assign w_owner_ar_valid = r_owner ? m1_ar_valid : m0_ar_valid;
    assign w_owner_r_ready  = r_owner ? m1_r_ready  : m0_r_ready;

    assign s_aw_valid  = m1_aw_valid;
    assign s_aw_addr   = m1_aw_addr;
    assign s_aw_len    = m1_aw_len;
    assign s_aw_size   = m1_aw_size;
    assign s_aw_burst  = m1_aw_burst;
    assign m1_aw_ready = s_aw_ready;
    assign s_w_valid   = m1_w_valid;
    assign s_w_data    = m1_w_data;
    assign s_w_strb    = m1_w_strb;
    assign m1_w_ready  = s_w_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        s_ar_valid       = 1'b0;
        s_r_ready        = 1'b0;
        m0_ar_ready      = 1'b0;
        m1_ar_ready      = 1'b0;
        m0_r_valid       = 1'b0;
        m1_r_valid       = 1'b0;
        m0_r_last        = 1'b0;
        m1_r_last        = 1'b0;
        m0_r_data        = '0;
        m1_r_data        = '0;
        case (r_state)
            IDLE: begin
                if (m0_ar_valid && m1_ar_valid) begin
                    w_owner_nxt = ~r_last_owner;
                    w_state_nxt = ADDR;
                end else if (m0_ar_valid) begin
                    w_owner_nxt = 1'b0;
                    w_state_nxt = ADDR;
                end else if (m1_ar_valid) begin
                    w_owner_nxt = 1'b1;
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                s_ar_valid = w_owner_ar_valid;
                if (r_owner) m1_ar_ready = s_ar_ready;
                else         m0_ar_ready = s_ar_ready;
                if (w_owner_ar_valid && s_ar_ready) w_state_nxt = DATA;
            end
            DATA: begin
                s_r_ready = w_owner_r_ready;
                if (r_owner) begin
                    m1_r_valid = s_r_valid;
                    m1_r_data  = s_r_data;
                    m1_r_last  = s_r_last;
                end else begin
                    m0_r_valid = s_r_valid;
                    m0_r_data  = s_r_data;
                    m0_r_last  = s_r_last;
                end
                if (s_r_valid && w_owner_r_ready && s_r_last) begin
                    w_state_nxt      = IDLE;
                    w_last_owner_nxt = r_owner;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050550_axi_rd_arbiter.sv
// tb/tb_ysyx_22050550_axi_rd_arbiter.sv - directed and randomized checks against a transaction-level arbiter model
module tb_ysyx_22050550_axi_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_last, m0_r_ready;
    logic [63:0] m0_ar_addr, m0_r_data;
    logic [7:0]  m0_ar_len;
    logic [2:0]  m0_ar_size;
    logic [1:0]  m0_ar_burst;
    logic        m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_last, m1_r_ready;
    logic [63:0] m1_ar_addr, m1_r_data;
    logic [7:0]  m1_ar_len;
    logic [2:0]  m1_ar_size;
    logic [1:0]  m1_ar_burst;
    logic        m1_aw_valid, m1_aw_ready, m1_w_valid, m1_w_ready;
    logic [63:0] m1_aw_addr, m1_w_data;
    logic [7:0]  m1_aw_len, m1_w_strb;
    logic [2:0]  m1_aw_size;
    logic [1:0]  m1_aw_burst;
    logic        s_ar_valid, s_ar_ready, s_r_valid, s_r_last, s_r_ready;
    logic [63:0] s_ar_addr, s_r_data;
    logic [7:0]  s_ar_len;
    logic [2:0]  s_ar_size;
    logic [1:0]  s_ar_burst;
    logic        s_aw_valid, s_aw_ready, s_w_valid, s_w_ready;
    logic [63:0] s_aw_addr, s_w_data;
    logic [7:0]  s_aw_len, s_w_strb;
    logic [2:0]  s_aw_size;
    logic [1:0]  s_aw_burst;

    int total = 0;
    int bad   = 0;

    ysyx_22050550_axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clock(clock), .reset(reset),
        .m0_ar_valid(m0_ar_valid), .m0_ar_addr(m0_ar_addr), .m0_ar_len(m0_ar_len),
        .m0_ar_size(m0_ar_size), .m0_ar_burst(m0_ar_burst), .m0_ar_ready(m0_ar_ready),
        .m0_r_valid(m0_r_valid), .m0_r_data(m0_r_data), .m0_r_last(m0_r_last), .m0_r_ready(m0_r_ready),
        .m1_ar_valid(m1_ar_valid), .m1_ar_addr(m1_ar_addr), .m1_ar_len(m1_ar_len),
        .m1_ar_size(m1_ar_size), .m1_ar_burst(m1_ar_burst), .m1_ar_ready(m1_ar_ready),
        .m1_r_valid(m1_r_valid), .m1_r_data(m1_r_data), .m1_r_last(m1_r_last), .m1_r_ready(m1_r_ready),
        .m1_aw_valid(m1_aw_valid), .m1_aw_addr(m1_aw_addr), .m1_aw_len(m1_aw_len),
        .m1_aw_size(m1_aw_size), .m1_aw_burst(m1_aw_burst), .m1_aw_ready(m1_aw_ready),
        .m1_w_valid(m1_w_valid), .m1_w_data(m1_w_data), .m1_w_strb(m1_w_strb), .m1_w_ready(m1_w_ready),
        .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len),
        .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_ready(s_ar_ready),
        .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_last(s_r_last), .s_r_ready(s_r_ready),
        .s_aw_valid(s_aw_valid), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len),
        .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_ready(s_aw_ready),
        .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_ready(s_w_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level model: who holds the slave (-1 = nobody), whether its address went out, whose turn a tie is.
    int m_holder = -1;
    bit m_sent   = 1'b0;
    int m_turn   = 0;
    bit m_live   = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_holder = -1;
            m_sent   = 1'b0;
            m_turn   = 0;
            m_live   = 1'b1;
        end else if (m_live) begin
            if (m_holder < 0) begin
                if (m0_ar_valid && m1_ar_valid) m_holder = m_turn;
                else if (m0_ar_valid)           m_holder = 0;
                else if (m1_ar_valid)           m_holder = 1;
            end else if (!m_sent) begin
                if ((m_holder == 0 ? m0_ar_valid : m1_ar_valid) && s_ar_ready) m_sent = 1'b1;
            end else if (s_r_valid && s_r_last && (m_holder == 0 ? m0_r_ready : m1_r_ready)) begin
                m_turn   = 1 - m_holder;
                m_holder = -1;
                m_sent   = 1'b0;
            end
        end
    end

    logic        e_arv, e_arr0, e_arr1, e_rr, e_rv0, e_rv1, e_rl0, e_rl1;
    logic [63:0] e_rd0, e_rd1;

    always @(negedge clock) begin
        if (m_live) begin
            e_arv = 0; e_arr0 = 0; e_arr1 = 0; e_rr = 0;
            e_rv0 = 0; e_rv1 = 0; e_rl0 = 0; e_rl1 = 0; e_rd0 = '0; e_rd1 = '0;
            if (m_holder >= 0 && !m_sent) begin
                e_arv = (m_holder == 0) ? m0_ar_valid : m1_ar_valid;
                if (m_holder == 0) e_arr0 = s_ar_ready; else e_arr1 = s_ar_ready;
            end else if (m_holder >= 0) begin
                e_rr = (m_holder == 0) ? m0_r_ready : m1_r_ready;
                if (m_holder == 0) begin e_rv0 = s_r_valid; e_rl0 = s_r_last; e_rd0 = s_r_data; end
                else               begin e_rv1 = s_r_valid; e_rl1 = s_r_last; e_rd1 = s_r_data; end
            end
            chk("s_ar_valid", s_ar_valid, e_arv);
            chk("m0_ar_ready", m0_ar_ready, e_arr0);
            chk("m1_ar_ready", m1_ar_ready, e_arr1);
            chk("s_r_ready", s_r_ready, e_rr);
            chk("m0_r_valid", m0_r_valid, e_rv0);
            chk("m1_r_valid", m1_r_valid, e_rv1);
            if (e_rv0) begin chk("m0_r_last", m0_r_last, e_rl0); chk("m0_r_data", m0_r_data, e_rd0); end
            if (e_rv1) begin chk("m1_r_last", m1_r_last, e_rl1); chk("m1_r_data", m1_r_data, e_rd1); end
            if (e_arv) begin
                chk("s_ar_addr", s_ar_addr, m_holder == 0 ? m0_ar_addr : m1_ar_addr);
                chk("s_ar_len", {56'd0, s_ar_len}, {56'd0, m_holder == 0 ? m0_ar_len : m1_ar_len});
                chk("s_ar_size", {61'd0, s_ar_size}, {61'd0, m_holder == 0 ? m0_ar_size : m1_ar_size});
                chk("s_ar_burst", {62'd0, s_ar_burst}, {62'd0, m_holder == 0 ? m0_ar_burst : m1_ar_burst});
            end
            chk("aw_fwd", {s_aw_valid, s_aw_len, s_aw_size, s_aw_burst, m1_aw_ready},
                          {m1_aw_valid, m1_aw_len, m1_aw_size, m1_aw_burst, s_aw_ready});
            chk("aw_addr_fwd", s_aw_addr, m1_aw_addr);
            chk("w_fwd", {s_w_valid, s_w_strb, m1_w_ready}, {m1_w_valid, m1_w_strb, s_w_ready});
            chk("w_data_fwd", s_w_data, m1_w_data);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic samp();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        m0_ar_valid = 0; m0_ar_addr = '0; m0_ar_len = '0; m0_ar_size = '0; m0_ar_burst = '0; m0_r_ready = 0;
        m1_ar_valid = 0; m1_ar_addr = '0; m1_ar_len = '0; m1_ar_size = '0; m1_ar_burst = '0; m1_r_ready = 0;
        m1_aw_valid = 0; m1_aw_addr = '0; m1_aw_len = '0; m1_aw_size = '0; m1_aw_burst = '0;
        m1_w_valid = 0; m1_w_data = '0; m1_w_strb = '0;
        s_ar_ready = 0; s_r_valid = 0; s_r_data = '0; s_r_last = 0; s_aw_ready = 0; s_w_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    logic [3:0] grants;
    int         ngr, t_m0last, t_m1ar;

    initial begin
        reset = 1;
        clear_inputs();
        do_reset();
        samp();
        chk("reset_s_ar_valid", s_ar_valid, 0);
        chk("reset_readies", {m0_ar_ready, m1_ar_ready, s_r_ready}, 0);
        chk("reset_r_out", {m0_r_valid, m1_r_valid, m0_r_last, m1_r_last}, 0);

        // single 4-beat ICache burst
        step();
        m0_ar_valid = 1; m0_ar_addr = 64'h8000_0000; m0_ar_len = 3; m0_ar_size = 3; m0_ar_burst = 1;
        m1_ar_addr = 64'h8000_4000;
        samp();
        chk("t1_no_ar_in_idle", s_ar_valid, 0);
        step(); samp();
        chk("t1_ar_valid", s_ar_valid, 1);
        chk("t1_ar_addr", s_ar_addr, 64'h8000_0000);
        chk("t1_ar_len", {56'd0, s_ar_len}, 3);
        step();
        s_ar_ready = 1;
        samp();
        chk("t1_ar_ready", m0_ar_ready, 1);
        step();
        m0_ar_valid = 0; s_ar_ready = 0; m0_r_ready = 1;
        for (int k = 0; k < 4; k++) begin
            s_r_valid = 1; s_r_data = 64'd100 + 64'(k); s_r_last = (k == 3);
            samp();
            chk("t1_beat_data", m0_r_data, 64'd100 + 64'(k));
            chk("t1_beat_last", m0_r_last, (k == 3) ? 1 : 0);
            chk("t1_m1_quiet", m1_r_valid, 0);
            step();
        end
        s_r_valid = 0; s_r_last = 0; m1_ar_valid = 1;
        samp();
        chk("t1_idle_after", s_ar_valid, 0);
        step(); samp();
        chk("t1_next_grant_addr", s_ar_addr, 64'h8000_4000);

        // simultaneous requests from reset, continuous traffic
        do_reset();
        m0_ar_valid = 1; m0_ar_addr = 64'h100; m1_ar_valid = 1; m1_ar_addr = 64'h200;
        s_ar_ready = 1; s_r_valid = 1; s_r_last = 1; m0_r_ready = 1; m1_r_ready = 1;
        grants = '0; ngr = 0; t_m0last = -1; t_m1ar = -1;
        for (int c = 0; c < 40 && ngr < 4; c++) begin
            samp();
            if (t_m0last < 0) chk("t2_m1_held", m1_ar_ready, 0);
            if (s_ar_valid && s_ar_ready) begin
                grants[ngr] = m1_ar_ready;
                ngr++;
            end
            if (m0_r_valid && m0_r_last && t_m0last < 0) t_m0last = c;
            if (s_ar_valid && s_ar_addr == 64'h200 && t_m1ar < 0) t_m1ar = c;
        end
        chk("t3_grant_count", 64'(ngr), 4);
        chk("t3_grant_order", {60'd0, grants}, 64'b1010);
        chk("t2_m1_gap", 64'(t_m1ar - t_m0last), 2);

        // ICache stalls R for 3 cycles
        do_reset();
        m0_ar_valid = 1; m0_ar_addr = 64'h300; s_ar_ready = 1;
        step(); step();
        m0_ar_valid = 0; s_ar_ready = 0;
        s_r_valid = 1; s_r_data = 64'h1122334455667788; s_r_last = 1; m0_r_ready = 0;
        for (int k = 0; k < 3; k++) begin
            samp();
            chk("t4_stall_ready", s_r_ready, 0);
            step();
        end
        m0_r_ready = 1;
        samp();
        chk("t4_ready", s_r_ready, 1);
        chk("t4_data", m0_r_data, 64'h1122334455667788);
        step();
        clear_inputs();

        // DCache single-beat read overlapping a write
        do_reset();
        m1_ar_valid = 1; m1_ar_addr = 64'h400; m1_ar_len = 0; s_ar_ready = 1;
        m1_aw_valid = 1; m1_aw_addr = 64'h8000_1000; m1_aw_size = 3; m1_aw_burst = 1;
        m1_w_valid = 1; m1_w_data = 64'hdead; m1_w_strb = 8'hff; s_aw_ready = 1; s_w_ready = 1;
        samp();
        chk("t5_aw_addr", s_aw_addr, 64'h8000_1000);
        chk("t5_w_data", s_w_data, 64'hdead);
        chk("t5_w_strb", {56'd0, s_w_strb}, 64'hff);
        step(); step();
        m1_ar_valid = 0; s_r_valid = 1; s_r_last = 1; s_r_data = 64'h55; m1_r_ready = 1;
        samp();
        chk("t5_r_valid", m1_r_valid, 1);
        chk("t5_r_last", m1_r_last, 1);
        chk("t5_w_during_r", s_w_data, 64'hdead);
        step();
        s_r_valid = 0;
        samp();
        chk("t5_done", m1_r_valid, 0);

        // reset at beat 2 of a 4-beat burst
        do_reset();
        m0_ar_valid = 1; m0_ar_addr = 64'h500; m0_ar_len = 3; s_ar_ready = 1;
        step(); step();
        m0_ar_valid = 0; s_ar_ready = 0; s_r_valid = 1; s_r_last = 0; m0_r_ready = 1;
        samp(); step(); samp();
        reset = 1;
        step(); samp();
        chk("t6_r_valid_dropped", m0_r_valid, 0);
        chk("t6_all_quiet", {s_ar_valid, s_r_ready, m0_ar_ready, m1_ar_ready}, 0);
        reset = 0; s_r_valid = 0; m1_ar_valid = 1; m1_ar_addr = 64'h600; s_ar_ready = 1;
        step(); samp();
        chk("t6_fresh_grant", {s_ar_valid, m1_ar_ready, m0_ar_ready}, 3'b110);
        chk("t6_fresh_addr", s_ar_addr, 64'h600);
        step();

        // randomized traffic
        clear_inputs();
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 299) == 0);
            m0_ar_valid = ($urandom_range(0, 1) == 1);
            m1_ar_valid = ($urandom_range(0, 1) == 1);
            m0_ar_addr  = {$urandom, $urandom};
            m1_ar_addr  = {$urandom, $urandom};
            m0_ar_len   = 8'($urandom); m1_ar_len = 8'($urandom);
            m0_ar_size  = 3'($urandom); m1_ar_size = 3'($urandom);
            m0_ar_burst = 2'($urandom); m1_ar_burst = 2'($urandom);
            m0_r_ready  = ($urandom_range(0, 9) < 7);
            m1_r_ready  = ($urandom_range(0, 9) < 7);
            s_ar_ready  = ($urandom_range(0, 1) == 1);
            s_r_valid   = ($urandom_range(0, 9) < 6);
            s_r_last    = ($urandom_range(0, 3) == 0);
            s_r_data    = {$urandom, $urandom};
            m1_aw_valid = ($urandom_range(0, 1) == 1);
            m1_aw_addr  = {$urandom, $urandom};
            m1_aw_len   = 8'($urandom); m1_aw_size = 3'($urandom); m1_aw_burst = 2'($urandom);
            m1_w_valid  = ($urandom_range(0, 1) == 1);
            m1_w_data   = {$urandom, $urandom};
            m1_w_strb   = 8'($urandom);
            s_aw_ready  = ($urandom_range(0, 1) == 1);
            s_w_ready   = ($urandom_range(0, 1) == 1);
            step();
        end
        reset = 0;
        samp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
